// File: rtl/decode_iq.sv
// decode_iq: fetch-to-decode instruction queue.
// DEPTH-entry FIFO carrying {instr, pc, pc+4, bpred} with valid/ready on both
// sides. The head entry is presented with its RV32 fields already sliced out
// for the decode stage. While the queue is empty, all head outputs are zero,
// so an empty queue looks like a bubble (an all-zero instruction).
//
// Optional feature: define IQ_BYPASS_EN to forward the fetch inputs straight
// to the head outputs in the same cycle while the queue is empty.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard all entries (mispredict/redirect)
//   in_valid/in_ready fetch-side handshake; instr_in, pc_in, pc_plus4_in, bpred_in
//   out_valid/out_ready decode-side handshake; instr, pc, pc_plus4, bpred_taken
//   rd_addr, r1_addr, r2_addr, funct3, funct7_6, csr_addr, zimm  head fields
//   count             occupancy
module decode_iq #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned ILEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ILEN-1:0]          instr_in,
   input  logic [XLEN-1:0]          pc_in,
   input  logic [XLEN-1:0]          pc_plus4_in,
   input  logic                     bpred_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ILEN-1:0]          instr,
   output logic [XLEN-1:0]          pc,
   output logic [XLEN-1:0]          pc_plus4,
   output logic                     bpred_taken,
   output logic [4:0]               rd_addr,
   output logic [4:0]               r1_addr,
   output logic [4:0]               r2_addr,
   output logic [2:0]               funct3,
   output logic                     funct7_6,
   output logic [11:0]              csr_addr,
   output logic [31:0]              zimm,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [ILEN-1:0] instr_mem [DEPTH];
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] pc4_mem   [DEPTH];
   logic            bp_mem    [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;

   logic empty;
   logic bypass;
   logic push;
   logic pop;

   assign empty    = (cnt == '0);
   assign in_ready = (cnt != CW'(DEPTH));
   assign count    = cnt;

`ifdef IQ_BYPASS_EN
   // Empty queue with fetch presenting: the input is visible at the head now.
   assign bypass    = empty & in_valid & ~flush;
   assign out_valid = (~empty | bypass) & ~flush;
   // A bypassed entry taken by decode the same cycle is never written.
   assign push      = in_valid & in_ready & ~(bypass & out_ready);
`else
   assign bypass    = 1'b0;
   assign out_valid = ~empty;
   assign push      = in_valid & in_ready;
`endif

   // Only stored entries advance rd_ptr; a bypassed entry leaves state alone.
   assign pop = ~empty & out_ready;

   // Head selection: stored entry, bypassed input, or an all-zero bubble.
   always_comb begin
      instr       = '0;
      pc          = '0;
      pc_plus4    = '0;
      bpred_taken = 1'b0;
      if (out_valid) begin
         if (bypass) begin
            instr       = instr_in;
            pc          = pc_in;
            pc_plus4    = pc_plus4_in;
            bpred_taken = bpred_in;
         end else begin
            instr       = instr_mem[rd_ptr];
            pc          = pc_mem[rd_ptr];
            pc_plus4    = pc4_mem[rd_ptr];
            bpred_taken = bp_mem[rd_ptr];
         end
      end
   end

   // Decoded fields are plain slices of the head instruction.
   assign rd_addr  = instr[11:7];
   assign r1_addr  = instr[19:15];
   assign r2_addr  = instr[24:20];
   assign funct3   = instr[14:12];
   assign funct7_6 = instr[30];
   assign csr_addr = instr[31:20];
   assign zimm     = 32'(r1_addr);

   // Storage is intentionally not reset; valid tracking is done by cnt.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= instr_in;
         pc_mem[wr_ptr]    <= pc_in;
         pc4_mem[wr_ptr]   <= pc_plus4_in;
         bp_mem[wr_ptr]    <= bpred_in;
      end
   end

   // Pointer and occupancy state; flush behaves exactly like reset.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      cnt <= cnt + CW'(1);
         else if (pop && !push) cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: tb/tb_decode_iq.sv
// tb_decode_iq: directed self-checking bench for decode_iq (DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_decode_iq;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr_in;
   logic [31:0] pc_in;
   logic [31:0] pc_plus4_in;
   logic        bpred_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        bpred_taken;
   logic [4:0]  rd_addr;
   logic [4:0]  r1_addr;
   logic [4:0]  r2_addr;
   logic [2:0]  funct3;
   logic        funct7_6;
   logic [11:0] csr_addr;
   logic [31:0] zimm;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decode_iq #(.DEPTH(4), .XLEN(32), .ILEN(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr_in(instr_in), .pc_in(pc_in), .pc_plus4_in(pc_plus4_in),
      .bpred_in(bpred_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .bpred_taken(bpred_taken),
      .rd_addr(rd_addr), .r1_addr(r1_addr), .r2_addr(r2_addr),
      .funct3(funct3), .funct7_6(funct7_6), .csr_addr(csr_addr),
      .zimm(zimm), .count(count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p, input logic bp);
      in_valid    = v;
      instr_in    = ins;
      pc_in       = p;
      pc_plus4_in = p + 32'd4;
      bpred_in    = bp;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      step(); step();
      rst = 1'b0;
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_pc", 64'(pc), 64'd0);
      check("rst_instr", 64'(instr), 64'd0);

      // Fill to full with decode stalled.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h1000 + 32'(i), 32'h100 + 32'(4 * i), i[0]);
         step();
      end
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_head_pc", 64'(pc), 64'h100);
      check("full_head_bp", 64'(bpred_taken), 64'd0);
      // Fifth push must be refused.
      drive(1'b1, 32'h1004, 32'h110, 1'b1);
      step();
      check("fifth_count", 64'(count), 64'd4);
      check("fifth_head_pc", 64'(pc), 64'h100);
      drive(1'b0, 32'h0, 32'h0, 1'b0);

      // Drain in order.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_pc", 64'(pc), 64'h100 + 64'(4 * i));
         check("drain_pc4", 64'(pc_plus4), 64'h104 + 64'(4 * i));
         check("drain_instr", 64'(instr), 64'h1000 + 64'(i));
         check("drain_bp", 64'(bpred_taken), 64'(i % 2));
         step();
      end
      check("empty_out_valid", 64'(out_valid), 64'd0);
      check("empty_instr", 64'(instr), 64'd0);
      check("empty_count", 64'(count), 64'd0);
      check("empty_pc", 64'(pc), 64'd0);

      // Steady push+pop at count=2, wrapping pointers.
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h3000 + 32'(i), 32'h300 + 32'(4 * i), 1'b0);
         step();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 32'h3002 + 32'(k), 32'h308 + 32'(4 * k), 1'b0);
         #1;
         check("stream_head_pc", 64'(pc), 64'h300 + 64'(4 * k));
         step();
         check("stream_count", 64'(count), 64'd2);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      for (int k = 10; k < 12; k++) begin
         #1;
         check("stream_tail_pc", 64'(pc), 64'h300 + 64'(4 * k));
         check("stream_tail_instr", 64'(instr), 64'h3000 + 64'(k));
         step();
      end
      check("stream_end_count", 64'(count), 64'd0);

      // Decoded fields.
      out_ready = 1'b0;
      drive(1'b1, 32'h34209073, 32'h700, 1'b0);
      step();
      drive(1'b1, 32'h3420D073, 32'h704, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      check("dec_csr", 64'(csr_addr), 64'h342);
      check("dec_r1", 64'(r1_addr), 64'd1);
      check("dec_funct3", 64'(funct3), 64'd1);
      check("dec_rd", 64'(rd_addr), 64'd0);
      check("dec_r2", 64'(r2_addr), 64'd2);
      check("dec_f7_6", 64'(funct7_6), 64'd0);
      out_ready = 1'b1;
      step();
      check("dec2_zimm", 64'(zimm), 64'h1);
      check("dec2_funct3", 64'(funct3), 64'd5);
      step();
      check("dec_bubble_csr", 64'(csr_addr), 64'd0);
      check("dec_bubble_zimm", 64'(zimm), 64'd0);
      check("dec_bubble_r1", 64'(r1_addr), 64'd0);

      // Flush at count=3 with a concurrent push.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h4000 + 32'(i), 32'h400 + 32'(4 * i), 1'b0);
         step();
      end
      check("preflush_count", 64'(count), 64'd3);
      flush = 1'b1;
      drive(1'b1, 32'h5000, 32'h500, 1'b1);
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      check("flush_count", 64'(count), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      drive(1'b1, 32'h6000, 32'h600, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      check("postflush_pc", 64'(pc), 64'h600);
      check("postflush_count", 64'(count), 64'd1);

      // Reset mid-stream clears the queue.
      rst = 1'b1;
      drive(1'b1, 32'h6100, 32'h610, 1'b0);
      out_ready = 1'b1;
      step();
      rst = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      out_ready = 1'b0;
      #1;
      check("midrst_count", 64'(count), 64'd0);
      check("midrst_out_valid", 64'(out_valid), 64'd0);

      // Empty queue, push with decode ready.
      out_ready = 1'b1;
      drive(1'b1, 32'h2000, 32'h200, 1'b0);
      #1;
`ifdef IQ_BYPASS_EN
      check("byp_out_valid", 64'(out_valid), 64'd1);
      check("byp_pc", 64'(pc), 64'h200);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      check("byp_count", 64'(count), 64'd0);
      check("byp_after_valid", 64'(out_valid), 64'd0);
`else
      check("nobyp_out_valid", 64'(out_valid), 64'd0);
      check("nobyp_pc", 64'(pc), 64'd0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      check("nobyp_next_pc", 64'(pc), 64'h200);
      check("nobyp_next_valid", 64'(out_valid), 64'd1);
      check("nobyp_next_count", 64'(count), 64'd1);
      step();
      check("nobyp_drained", 64'(count), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
